// File: rtl/gshare_branch_predictor.sv
// gshare_branch_predictor
//   Direction predictor for conditional branches in the fetch stage. The
//   counter table index is the word-aligned fetch PC XORed with a speculative
//   global history. The prediction is returned combinationally in the same
//   cycle. Resolved outcomes train the table and advance an architectural
//   history. On a mispredict or a flush, the speculative history is repaired
//   from the architectural history.
//
// Ports
//   clk                 single clock, rising-edge state updates
//   reset_n             asynchronous active-low reset
//   lookup_pc           PC of the instruction being fetched
//   lookup_valid        fetch slot holds a valid instruction
//   lookup_is_branch    pre-decode flags a conditional branch
//   predict_taken       predicted direction (combinational)
//   predict_index       table index used, carried down the pipe with the branch
//   update_valid        a conditional branch resolved this cycle
//   update_index        predict_index that travelled with the resolved branch
//   update_taken        actual direction
//   update_mispredicted direction mispredicted (qualified by update_valid)
//   flush               pipeline flush not covered by an update
module gshare_branch_predictor #(
  parameter int XLEN         = 32,
  parameter int INDEX_BITS   = 6,
  parameter int HISTORY_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [XLEN-1:0]       lookup_pc,
  input  logic                  lookup_valid,
  input  logic                  lookup_is_branch,
  output logic                  predict_taken,
  output logic [INDEX_BITS-1:0] predict_index,
  input  logic                  update_valid,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken,
  input  logic                  update_mispredicted,
  input  logic                  flush
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  logic [1:0]              ctr_r [ENTRIES];
  logic [HISTORY_BITS-1:0] spec_ghr_r;
  logic [HISTORY_BITS-1:0] arch_ghr_r;
  logic [HISTORY_BITS-1:0] next_arch_s;
  logic [HISTORY_BITS-1:0] next_spec_s;
  logic                    recover_s;
  logic                    pc_unused_s;

  // Shift a new outcome into the history. A shift followed by a load of
  // bit 0 works for every legal length. For a one-bit history it simply
  // loads the new bit.
  function automatic logic [HISTORY_BITS-1:0] shift_in(
    input logic [HISTORY_BITS-1:0] ghr,
    input logic                    bit_in
  );
    logic [HISTORY_BITS-1:0] res;
    res    = ghr << 1;
    res[0] = bit_in;
    return res;
  endfunction

  // Saturating 2-bit counter step: 00 strong-NT ... 11 strong-T.
  function automatic logic [1:0] ctr_step(
    input logic [1:0] cnt,
    input logic       taken
  );
    logic [1:0] res;
    case ({taken, cnt})
      3'b1_11: res = 2'b11;
      3'b0_00: res = 2'b00;
      3'b1_00, 3'b1_01, 3'b1_10: res = cnt + 2'b01;
      3'b0_01, 3'b0_10, 3'b0_11: res = cnt - 2'b01;
      default: res = cnt;
    endcase
    return res;
  endfunction

  // The PC bits outside the index field carry no prediction information.
  assign pc_unused_s = &{1'b0, lookup_pc[XLEN-1:INDEX_BITS+2], lookup_pc[1:0]};

  // The history occupies the low bits of the index. The history is
  // zero-extended to the index width.
  assign predict_index = lookup_pc[INDEX_BITS+1:2] ^ INDEX_BITS'(spec_ghr_r);
  // There is no bypass. A same-cycle update to this entry is seen next cycle.
  assign predict_taken = ctr_r[predict_index][1];

  // Next-state selection for both histories. Recovery takes priority, so a
  // lookup in the same cycle as a flush or mispredict loses its shift.
  always_comb begin
    next_arch_s = arch_ghr_r;
    next_spec_s = spec_ghr_r;
    recover_s   = (update_valid && update_mispredicted) || flush;
    if (update_valid) begin
      next_arch_s = shift_in(arch_ghr_r, update_taken);
    end else begin
      next_arch_s = arch_ghr_r;
    end
    if (recover_s) begin
      next_spec_s = next_arch_s;
    end else if (lookup_valid && lookup_is_branch) begin
      next_spec_s = shift_in(spec_ghr_r, predict_taken);
    end else begin
      next_spec_s = spec_ghr_r;
    end
  end

  // History registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spec_ghr_r <= {HISTORY_BITS{1'b0}};
      arch_ghr_r <= {HISTORY_BITS{1'b0}};
    end else begin
      spec_ghr_r <= next_spec_s;
      arch_ghr_r <= next_arch_s;
    end
  end

  // Counter table in flops. Reset makes every entry weakly not-taken, so
  // the first taken outcome flips the prediction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_r[i] <= 2'b01;
      end
    end else if (update_valid) begin
      ctr_r[update_index] <= ctr_step(ctr_r[update_index], update_taken);
    end
  end

endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench for gshare_branch_predictor. Expected values are pushed to a
// scoreboard queue as each step is driven. Each value is popped and compared
// when the DUT output is sampled.
module tb_gshare_branch_predictor;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] lookup_pc;
  logic        lookup_valid;
  logic        lookup_is_branch;
  logic        predict_taken;
  logic [5:0]  predict_index;
  logic        update_valid;
  logic [5:0]  update_index;
  logic        update_taken;
  logic        update_mispredicted;
  logic        flush;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } sb_t;
  sb_t sb_q[$];

  gshare_branch_predictor dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .lookup_pc          (lookup_pc),
    .lookup_valid       (lookup_valid),
    .lookup_is_branch   (lookup_is_branch),
    .predict_taken      (predict_taken),
    .predict_index      (predict_index),
    .update_valid       (update_valid),
    .update_index       (update_index),
    .update_taken       (update_taken),
    .update_mispredicted(update_mispredicted),
    .flush              (flush)
  );

  always #5 clk = ~clk;

  task automatic exp_push(input string tag, input logic [31:0] val);
    sb_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed %h expected <entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [5:0] idx, input logic taken);
    update_valid = 1'b1;
    update_index = idx;
    update_taken = taken;
    tick();
    update_valid = 1'b0;
    update_taken = 1'b0;
  endtask

  // Drive a branch lookup for one edge. Check its combinational result.
  task automatic br_lookup(input logic [31:0] pc, input logic [5:0] exp_idx,
                           input logic exp_taken);
    lookup_pc        = pc;
    lookup_valid     = 1'b1;
    lookup_is_branch = 1'b1;
    #1;
    exp_push("lookup_index", 32'(exp_idx));
    chk(32'(predict_index));
    exp_push("lookup_taken", 32'(exp_taken));
    chk(32'(predict_taken));
    tick();
    lookup_valid     = 1'b0;
    lookup_is_branch = 1'b0;
  endtask

  initial begin
    reset_n             = 1'b0;
    lookup_pc           = 32'h0000_0100;
    lookup_valid        = 1'b0;
    lookup_is_branch    = 1'b0;
    update_valid        = 1'b0;
    update_index        = 6'h00;
    update_taken        = 1'b0;
    update_mispredicted = 1'b0;
    flush               = 1'b0;
    #1;
    exp_push("rst_index", 32'h0);  chk(32'(predict_index));
    exp_push("rst_taken", 32'h0);  chk(32'(predict_taken));

    // Release reset between clock edges.
    #11 reset_n = 1'b1;
    #1;
    exp_push("post_rst_index", 32'h0); chk(32'(predict_index));
    exp_push("post_rst_taken", 32'h0); chk(32'(predict_taken));
    for (int i = 0; i < 64; i++) begin
      exp_push("ctr_reset", 32'h1);
      chk(32'(dut.ctr_r[i]));
    end
    exp_push("spec_rst", 32'h0); chk(32'(dut.spec_ghr_r));
    exp_push("arch_rst", 32'h0); chk(32'(dut.arch_ghr_r));

    // Saturation on index 5. With history 0, pc 0x14 maps to index 5.
    lookup_pc = 32'h0000_0014;
    upd(6'h05, 1'b1); upd(6'h05, 1'b1); upd(6'h05, 1'b1);
    exp_push("sat_idx", 32'h05);  chk(32'(predict_index));
    exp_push("sat_ctr3", 32'h3);  chk(32'(dut.ctr_r[5]));
    exp_push("sat_pred3", 32'h1); chk(32'(predict_taken));
    upd(6'h05, 1'b1);
    exp_push("sat_ctr4", 32'h3);  chk(32'(dut.ctr_r[5]));
    upd(6'h05, 1'b0);
    exp_push("sat_nt1_ctr", 32'h2);  chk(32'(dut.ctr_r[5]));
    exp_push("sat_nt1_pred", 32'h1); chk(32'(predict_taken));
    upd(6'h05, 1'b0);
    exp_push("sat_nt2_ctr", 32'h1);  chk(32'(dut.ctr_r[5]));
    exp_push("sat_nt2_pred", 32'h0); chk(32'(predict_taken));
    upd(6'h05, 1'b0); upd(6'h05, 1'b0);
    exp_push("sat_floor", 32'h0); chk(32'(dut.ctr_r[5]));
    exp_push("sat_arch", 32'h0);  chk(32'(dut.arch_ghr_r));
    exp_push("sat_spec", 32'h0);  chk(32'(dut.spec_ghr_r));

    // Speculative history. The update shifts arch to 0001.
    upd(6'h00, 1'b1);
    exp_push("train0", 32'h2); chk(32'(dut.ctr_r[0]));
    br_lookup(32'h0000_0100, 6'h00, 1'b1);
    exp_push("spec_after_br", 32'h1); chk(32'(dut.spec_ghr_r));
    lookup_pc = 32'h0000_0100;
    #1;
    exp_push("spec_index", 32'h01); chk(32'(predict_index));
    lookup_valid = 1'b1; lookup_is_branch = 1'b0; tick();
    lookup_valid = 1'b0; lookup_is_branch = 1'b1; tick();
    lookup_is_branch = 1'b0;
    exp_push("spec_nonbranch", 32'h1); chk(32'(dut.spec_ghr_r));

    // Mispredict recovery. First bring arch to 0000 and spec to 0111.
    for (int i = 0; i < 4; i++) upd(6'h3F, 1'b0);
    br_lookup(32'h0000_0004, 6'h00, 1'b1);  // spec 0001 -> 0011
    br_lookup(32'h0000_000C, 6'h00, 1'b1);  // spec 0011 -> 0111
    exp_push("mp_pre_spec", 32'h7); chk(32'(dut.spec_ghr_r));
    exp_push("mp_pre_arch", 32'h0); chk(32'(dut.arch_ghr_r));
    update_valid = 1'b1; update_index = 6'h3F; update_taken = 1'b0;
    update_mispredicted = 1'b1;
    lookup_pc = 32'h0000_001C; lookup_valid = 1'b1; lookup_is_branch = 1'b1;
    tick();
    update_valid = 1'b0; update_mispredicted = 1'b0;
    lookup_valid = 1'b0; lookup_is_branch = 1'b0;
    exp_push("mp_spec", 32'h0); chk(32'(dut.spec_ghr_r));
    exp_push("mp_arch", 32'h0); chk(32'(dut.arch_ghr_r));

    // Flush. Set arch to 0001 and spec to 0011.
    upd(6'h3F, 1'b1);
    br_lookup(32'h0000_0000, 6'h00, 1'b1);
    br_lookup(32'h0000_0004, 6'h00, 1'b1);
    exp_push("fl_pre_spec", 32'h3); chk(32'(dut.spec_ghr_r));
    flush = 1'b1; tick(); flush = 1'b0;
    exp_push("fl_spec", 32'h1); chk(32'(dut.spec_ghr_r));
    br_lookup(32'h0000_0004, 6'h00, 1'b1);  // spec back to 0011
    flush = 1'b1;
    update_valid = 1'b1; update_index = 6'h3F; update_taken = 1'b1;
    tick();
    flush = 1'b0; update_valid = 1'b0; update_taken = 1'b0;
    exp_push("fl_upd_spec", 32'h3); chk(32'(dut.spec_ghr_r));
    exp_push("fl_upd_arch", 32'h3); chk(32'(dut.arch_ghr_r));

    // Same-cycle read/write. With spec 0011, pc 0x4C maps to index 0x10.
    lookup_pc = 32'h0000_004C; lookup_valid = 1'b1;
    update_valid = 1'b1; update_index = 6'h10; update_taken = 1'b1;
    #1;
    exp_push("hz_index", 32'h10); chk(32'(predict_index));
    exp_push("hz_pre", 32'h0);    chk(32'(predict_taken));
    tick();
    update_valid = 1'b0;
    exp_push("hz_post", 32'h1); chk(32'(predict_taken));

    // Async reset mid-cycle while an update is pending.
    update_valid = 1'b1; update_index = 6'h10; update_taken = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    exp_push("ar_ctr10", 32'h1);  chk(32'(dut.ctr_r[16]));
    exp_push("ar_ctr0", 32'h1);   chk(32'(dut.ctr_r[0]));
    exp_push("ar_spec", 32'h0);   chk(32'(dut.spec_ghr_r));
    exp_push("ar_arch", 32'h0);   chk(32'(dut.arch_ghr_r));
    exp_push("ar_index", 32'h13); chk(32'(predict_index));
    exp_push("ar_taken", 32'h0);  chk(32'(predict_taken));
    update_valid = 1'b0;
    tick();
    reset_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
